if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction fetch stage for the single-issue RV32I core. It is the producer side of the decode interface: it drives the 7-bit opcode into the control unit and the full instruction word into decode.
- It owns the PC and issues word reads to instruction memory, which has a fixed 1-cycle read latency.
- Fetched words are buffered in a small FIFO so decode back-pressure never drops an instruction.
- Branch/jump resolution redirects the PC and squashes all buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
DEPTH, 2, instruction buffer entries (power of 2, >= 2)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-low reset
im_en  output  1  instruction memory read enable
im_addr  output  32  byte address of read, always word aligned
im_rdata  input  32  read data, valid the cycle after im_en=1
if_valid  output  1  buffer head holds a valid instruction
if_instr  output  32  buffer head instruction; NOP when if_valid=0
if_op  output  7  if_instr[6:0], wired to control unit OP
if_pc  output  32  PC of buffer head; 0 when if_valid=0
id_ready  input  1  decode accepts head this cycle
redirect  input  1  branch taken / jump resolved
redirect_pc  input  32  new fetch target; bits [1:0] ignored (treated as 00)

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, in-flight flag=0, FIFO empty, im_en=0, if_valid=0, if_instr=32'h0000_0013, if_op=7'b0010011, if_pc=0.
- Pop: if_valid && id_ready at a rising edge removes the head.
- Issue rule: im_en=1 when rst=1 && !redirect && (count + inflight - pop) < DEPTH. With DEPTH=2 and id_ready held high, sustained throughput is one instruction per cycle.
- Issue effects: im_addr=pc (combinational from the PC register). At the edge, pc <= pc+4 (32-bit wrap: FFFF_FFFC -> 0000_0000), and inflight <= 1 with the tag {pc} recorded.
- Response: in the cycle after issue, im_rdata and the recorded PC are pushed into the FIFO at the edge, unless the response is squashed.
- Latency: issue in cycle t, if_valid visible in cycle t+2 (FIFO output is registered-head, no bypass).
- Redirect (cycle r):
  - im_en=0 in cycle r.
  - At the edge: FIFO is cleared, pc <= {redirect_pc[31:2],2'b00}, and any response arriving in cycle r is discarded (squash flag set by an issue in cycle r-1).
  - First fetch of the new target issues in r+1; its if_valid appears in r+3.
- Redirect and pop in the same cycle: the pop is accepted (decode saw the head) and the flush still clears everything else.
- Redirect while FIFO empty and nothing in flight: same as above, no spurious push.
- Full FIFO with id_ready=0: no issue, head and outputs held stable. If a response is in flight, the credit rule guarantees it has room.
- FIFO pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits. Push and pop in the same cycle keep count unchanged.
- No illegal states: after reset, count never exceeds DEPTH and count+inflight never exceeds DEPTH.
- Reset mid-operation: all state returns to reset values immediately. A response arriving after reset deassertion from a pre-reset issue is ignored, because inflight was cleared.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants OP_RTYPE=0110011, OP_ITYPE=0010011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011, OP_LUI=0110111, OP_JAL=1101111
  - NOP_INSTR=32'h0000_0013
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}
- One sub-module, if_fifo: a DEPTH-entry sync FIFO of fetch_entry_t with push, pop, flush, count, empty, full and an async active-low rst.
- Top level: PC register, inflight/squash flags, credit logic.

Test Plan:
1. Reset: hold rst=0 for 2 cycles, then release with id_ready=1 and im_rdata returning mem[addr/4].
   - Cycle 1: im_en=1, im_addr=0.
   - Cycle 3: if_valid=1, if_pc=0.
   - Thereafter one instruction per cycle at PC 0,4,8,...
   - if_op tracks instr[6:0].
2. Back-pressure: stream, then drop id_ready to 0 for 5 cycles.
   - im_en falls once count=2.
   - if_instr/if_pc stay stable.
   - On re-raise, no instruction is skipped or duplicated (PC sequence contiguous).
3. Redirect with in-flight fetch: assert redirect, redirect_pc=32'h0000_0103 in a cycle following an issue.
   - Squashed response is not pushed.
   - Next im_addr=32'h0000_0100.
   - if_valid=0 until 2 cycles after that issue, then if_pc=0x100.
4. Redirect coincident with pop while FIFO holds 2 entries: the popped entry is counted as consumed, the remaining entry is flushed, and count=0 next cycle.
5. Wrap: RESET_PC=32'hFFFF_FFF8. im_addr sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
6. Mid-stream reset: drop rst for 1 cycle while a fetch is in flight and FIFO is full.
   - All outputs take reset values immediately.
   - The next if_pc after release equals RESET_PC.
   - The stale im_rdata is never presented.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I opcode constants and the fetch buffer entry type.
package rv_pkg;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/if_fifo.sv
// if_fifo: DEPTH-entry sync FIFO of fetch entries with flush; head is read straight from storage.
module if_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rdPtr, wrPtr;
  logic doPush, doPop;
  assign doPush = push && !full && !flush;
  assign doPop  = pop && !empty;
  assign empty  = count == '0;
  assign full   = count == CW'(DEPTH);
  assign head   = mem[rdPtr];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop) rdPtr <= rdPtr + AW'(1);
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC register, 1-cycle imem issue with credit flow control and redirect squash,
// feeding a small instruction buffer toward decode.
module if_fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_en,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [6:0]  if_op,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [31:0] pc, tagPc, target;
  logic inflight, pop, push, fifoEmpty, fifoFull;
  logic [CW-1:0] count;
  logic [CW:0] credit;
  fetch_entry_t head;
  assign target   = redirect_pc & ~32'd3;
  assign pop      = if_valid && id_ready;
  // A response landing in the redirect cycle belongs to the old path.
  assign push     = inflight && !redirect;
  assign credit   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign im_en    = rst && !redirect && !(fifoFull && !pop) && credit < (CW+1)'(DEPTH);
  assign im_addr  = pc;
  assign if_valid = !fifoEmpty;
  assign if_instr = if_valid ? head.instr : NOP_INSTR;
  assign if_pc    = if_valid ? head.pc : '0;
  assign if_op    = if_instr[6:0];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      tagPc    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= im_en;
      if (redirect) pc <= target;
      else if (im_en) begin
        pc    <= pc + 32'd4;
        tagPc <= pc;
      end
    end
  end
  if_fifo #(.DEPTH(DEPTH)) buffer (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ('{pc: tagPc, instr: im_rdata}),
    .head  (head),
    .count (count),
    .empty (fifoEmpty),
    .full  (fifoFull)
  );
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed stimulus with a queue-based fetch model checked every cycle,
// plus literal checks for reset, back-pressure, redirect, wrap and mid-stream reset.
module tb_if_fetch_unit;
  import rv_pkg::*;
  localparam int DEPTH = 2;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
  logic clk = 0, rst, id_ready, redirect;
  logic [31:0] redirect_pc;
  logic im_en, if_valid, im_en2, if_valid2;
  logic [31:0] im_addr, im_rdata, if_instr, if_pc, im_addr2, im_rdata2, if_instr2, if_pc2;
  logic [6:0] if_op, if_op2;
  int asserts = 0, fails = 0;
  logic [31:0] q[$];
  bit infl;
  logic [31:0] inflPc, mpc, hold;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .im_en(im_en), .im_addr(im_addr), .im_rdata(im_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_op(if_op), .if_pc(if_pc),
    .id_ready(id_ready), .redirect(redirect), .redirect_pc(redirect_pc));

  if_fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dutWrap (
    .clk(clk), .rst(rst), .im_en(im_en2), .im_addr(im_addr2), .im_rdata(im_rdata2),
    .if_valid(if_valid2), .if_instr(if_instr2), .if_op(if_op2), .if_pc(if_pc2),
    .id_ready(id_ready), .redirect(redirect), .redirect_pc(redirect_pc));

  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [6:0] op;
    case (a[4:2])
      3'd0: op = OP_RTYPE;
      3'd1: op = OP_ITYPE;
      3'd2: op = OP_LOAD;
      3'd3: op = OP_STORE;
      3'd4: op = OP_BRANCH;
      3'd5: op = OP_LUI;
      3'd6: op = OP_JAL;
      default: op = OP_ITYPE;
    endcase
    return {a[26:2], op};
  endfunction

  always @(posedge clk) begin
    im_rdata  <= im_en  ? memf(im_addr)  : 32'hDEAD_BEEF;
    im_rdata2 <= im_en2 ? memf(im_addr2) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: fetched PCs flow through a queue bounded by DEPTH credits.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_rst_en", im_en, 0);
      chk("m_rst_valid", if_valid, 0);
      chk("m_rst_instr", if_instr, NOP_INSTR);
      chk("m_rst_pc", if_pc, 0);
      q.delete();
      infl = 0;
      mpc = 32'h0;
    end else begin
      automatic bit expValid = q.size() > 0;
      automatic bit pop = expValid && id_ready;
      automatic bit en = !redirect && (q.size() + int'(infl) - int'(pop)) < DEPTH;
      automatic logic [31:0] expInstr = expValid ? memf(q[0]) : NOP_INSTR;
      chk("m_valid", if_valid, expValid);
      chk("m_pc", if_pc, expValid ? q[0] : 32'h0);
      chk("m_instr", if_instr, expInstr);
      chk("m_op", if_op, expInstr[6:0]);
      chk("m_en", im_en, en);
      if (en) chk("m_addr", im_addr, mpc);
      if (pop) void'(q.pop_front());
      if (redirect) begin
        q.delete();
        mpc = {redirect_pc[31:2], 2'b00};
      end else if (infl) q.push_back(inflPc);
      if (en) begin
        inflPc = mpc;
        mpc = mpc + 32'd4;
      end
      infl = en;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 0; id_ready = 1; redirect = 0; redirect_pc = 0;
    tick; tick;
    rst = 1;
    @(negedge clk);
    chk("c1_en", im_en, 1);
    chk("c1_addr", im_addr, 32'h0);
    chk("wrap_addr0", im_addr2, 32'hFFFF_FFF8);
    tick; @(negedge clk);
    chk("c2_valid", if_valid, 0);
    chk("wrap_addr1", im_addr2, 32'hFFFF_FFFC);
    tick; @(negedge clk);
    chk("c3_valid", if_valid, 1);
    chk("c3_pc", if_pc, 32'h0);
    chk("c3_instr", if_instr, 32'h0000_0033);
    chk("wrap_addr2", im_addr2, 32'h0000_0000);
    chk("wrap_pc0", if_pc2, 32'hFFFF_FFF8);
    tick; @(negedge clk);
    chk("c4_pc", if_pc, 32'h4);
    chk("c4_instr", if_instr, 32'h0000_0093);
    chk("c4_op", if_op, OP_ITYPE);
    chk("wrap_pc1", if_pc2, 32'hFFFF_FFFC);
    repeat (4) tick;
    // back-pressure
    id_ready = 0;
    hold = if_pc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_pc", if_pc, hold);
      if (i > 0) chk("stall_en", im_en, 0);
      tick;
    end
    id_ready = 1;
    @(negedge clk);
    chk("resume_pc0", if_pc, hold);
    tick; @(negedge clk);
    chk("resume_pc1", if_pc, hold + 32'd4);
    repeat (3) tick;
    // redirect following an issue
    redirect = 1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    chk("r_en", im_en, 0);
    tick; redirect = 0;
    @(negedge clk);
    chk("r1_en", im_en, 1);
    chk("r1_addr", im_addr, 32'h100);
    chk("r1_valid", if_valid, 0);
    tick; @(negedge clk);
    chk("r2_valid", if_valid, 0);
    tick; @(negedge clk);
    chk("r3_valid", if_valid, 1);
    chk("r3_pc", if_pc, 32'h100);
    tick;
    // redirect coincident with pop on a full buffer
    id_ready = 0;
    repeat (3) tick;
    @(negedge clk);
    chk("full_en", im_en, 0);
    chk("full_valid", if_valid, 1);
    tick;
    id_ready = 1; redirect = 1; redirect_pc = 32'h0000_0200;
    tick; redirect = 0;
    @(negedge clk);
    chk("rp1_valid", if_valid, 0);
    chk("rp1_addr", im_addr, 32'h200);
    tick; tick; @(negedge clk);
    chk("rp3_pc", if_pc, 32'h200);
    tick;
    // back-to-back redirects: second one sees an empty, idle fetch path
    redirect = 1; redirect_pc = 32'h0000_0300;
    tick; redirect_pc = 32'h0000_0402;
    tick; redirect = 0;
    @(negedge clk);
    chk("rr_addr", im_addr, 32'h400);
    tick; tick; @(negedge clk);
    chk("rr_pc", if_pc, 32'h400);
    tick;
    // mid-stream reset with the buffer occupied and a fetch in flight
    id_ready = 0;
    repeat (3) tick;
    id_ready = 1;
    tick;
    rst = 0;
    #1;
    chk("mr_valid", if_valid, 0);
    chk("mr_en", im_en, 0);
    chk("mr_instr", if_instr, NOP_INSTR);
    chk("mr_op", if_op, 7'b0010011);
    chk("mr_pc", if_pc, 32'h0);
    tick;
    rst = 1;
    @(negedge clk);
    chk("mr1_addr", im_addr, 32'h0);
    chk("mr1_valid", if_valid, 0);
    tick; tick; @(negedge clk);
    chk("mr3_valid", if_valid, 1);
    chk("mr3_pc", if_pc, 32'h0);
    chk("mr3_instr", if_instr, 32'h0000_0033);
    repeat (6) tick;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
